// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR engine coefficient path.
package fir_pkg;
   localparam int CMEM_ADDR_W = 6;
   localparam int CMEM_DATA_W = 17;

   typedef struct packed {
      logic [CMEM_ADDR_W-1:0] addr;
      logic [CMEM_DATA_W-1:0] data;
   } coef_wr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Generic synchronous FIFO; full/empty are registered so consumers see no path from push/pop.
module fir_sync_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMEM_ADDR_W + CMEM_DATA_W
) (
   input  logic                    clk_fast,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        push_dat_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        head_dat_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_q, empty_q;
   logic             push_ok, pop_ok;

   assign push_ok    = push_i & ~full_q;
   assign pop_ok     = pop_i & ~empty_q;
   assign head_dat_o = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign count_o    = count_q;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == (PTR_W+1)'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: entries are only read while the count says they are valid.
   always_ff @(posedge clk_fast) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end
endmodule

// File: rtl/fir_coef_port_arb.sv
// CMEM port arbiter: sequencer reads always win; buffered host writes drain only outside seq_busy.
// A write accepted at one edge reaches CMEM in the very next cycle when the port is free.
module fir_coef_port_arb
   import fir_pkg::*;
#(
   parameter int ADDR_W     = CMEM_ADDR_W,
   parameter int DATA_W     = CMEM_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_fast,
   input  logic              rst_n,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [ADDR_W-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data,
   input  logic              seq_busy,
   input  logic              seq_rd_en,
   input  logic [ADDR_W-1:0] seq_rd_addr,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              coef_dirty,
   output logic              coef_commit,
   output logic [7:0]        defer_cnt
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [ADDR_W+DATA_W-1:0] head_dat;
   logic [CNT_W-1:0]         fifo_count;
   logic                     fifo_full, fifo_empty;
   logic                     push, pop;
   arb_state_t               state;

   logic [ADDR_W-1:0]        mem_addr_q;
   logic [DATA_W-1:0]        mem_wdata_q;
   logic                     coef_commit_q;
   logic [7:0]               defer_cnt_q;

   fir_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_wr_fifo (
      .clk_fast   (clk_fast),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i ({host_wr_addr, host_wr_data}),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign host_wr_ready = ~fifo_full;
   assign push          = host_wr_valid & host_wr_ready;
   assign coef_dirty    = ~fifo_empty;
   assign coef_commit   = coef_commit_q;
   assign defer_cnt     = defer_cnt_q;

   // State follows the live seq_busy so a write is never issued in a busy cycle.
   always_comb begin
      state = IDLE;
      if (!fifo_empty) state = seq_busy ? WAIT : DRAIN;
   end

   assign pop = (state == DRAIN) & ~seq_rd_en;

   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      if (seq_rd_en) begin
         mem_cs   = 1'b1;
         mem_addr = seq_rd_addr;
      end else if (state == DRAIN) begin
         mem_cs    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = head_dat[ADDR_W+DATA_W-1:DATA_W];
         mem_wdata = head_dat[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         coef_commit_q <= 1'b0;
         defer_cnt_q   <= '0;
      end else begin
         mem_addr_q    <= mem_addr;
         mem_wdata_q   <= mem_wdata;
         coef_commit_q <= pop & (fifo_count == CNT_W'(1)) & ~push;
         if (state == WAIT && defer_cnt_q != 8'hFF) defer_cnt_q <= defer_cnt_q + 8'd1;
      end
   end
endmodule
